// File: rtl/fp16_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : fp16_mul_sched
// Purpose  : Round-robin scheduler that shares one pipelined FP16 multiplier
//            among NREQ requesters. At most one operand pair is issued per
//            cycle. The requester ID travels with each operation through a
//            tag pipeline, and the product is returned to its owner on a
//            one-hot response strobe.
// Ports    : clk, rst_n (sync, active-low), ena (grant enable)
//            req_valid/req_a/req_b/req_ready  - per-requester handshake
//            mul_valid/mul_a/mul_b/mul_result - shared multiplier interface
//            rsp_valid/rsp_data               - one-hot result return
//            busy                             - any operation in flight
// Revision : 1.0 - initial release
// ============================================================================
module fp16_mul_sched #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 mul_valid,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_result,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 busy
);

  localparam int              c_ptr_w = $clog2(NREQ);
  localparam logic [NREQ-1:0] c_one   = NREQ'(1);

  logic [c_ptr_w-1:0] r_rr_ptr;
  logic [NREQ-1:0]    r_outstanding;
  logic               r_mul_valid;
  logic [15:0]        r_mul_a;
  logic [15:0]        r_mul_b;
  logic [NREQ-1:0]    r_rsp_valid;
  logic [15:0]        r_rsp_data;

  // Tag pipeline: stage 0 is loaded on the issue edge, stage MUL_LAT lines up
  // with the cycle in which mul_result carries that operation's product.
  logic [MUL_LAT:0]   r_tag_v;
  logic [c_ptr_w-1:0] r_tag_id [0:MUL_LAT];

  logic [NREQ-1:0]    w_eligible;
  logic [NREQ-1:0]    w_grant;
  logic               w_grant_any;
  logic [c_ptr_w-1:0] w_grant_idx;
  logic [15:0]        w_sel_a;
  logic [15:0]        w_sel_b;
  logic               w_retire;
  logic [NREQ-1:0]    w_clr;

  assign w_eligible = req_valid & ~r_outstanding & {NREQ{ena & rst_n}};

  // Search starts one past the last granted index so every requester gets a
  // turn. Grant implies req_valid, so a grant is always a handshake.
  always_comb begin : p_grant
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_sel_a     = '0;
    w_sel_b     = '0;
    for (int off = 1; off <= NREQ; off++) begin
      int idx;
      idx = (int'(r_rr_ptr) + off) % NREQ;
      if (!w_grant_any && w_eligible[idx]) begin
        w_grant_any  = 1'b1;
        w_grant[idx] = 1'b1;
        w_grant_idx  = c_ptr_w'(idx);
        w_sel_a      = req_a[16*idx +: 16];
        w_sel_b      = req_b[16*idx +: 16];
      end
    end
  end

  assign w_retire = r_tag_v[MUL_LAT];
  assign w_clr    = w_retire ? (c_one << r_tag_id[MUL_LAT]) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr      <= c_ptr_w'(NREQ-1);
      r_outstanding <= '0;
      r_mul_valid   <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_tag_v       <= '0;
      for (int s = 0; s <= MUL_LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_mul_valid <= w_grant_any;
      if (w_grant_any) begin
        r_mul_a  <= w_sel_a;
        r_mul_b  <= w_sel_b;
        r_rr_ptr <= w_grant_idx;
      end
      // Shifts every cycle regardless of ena: the multiplier never stalls.
      r_tag_v     <= {r_tag_v[MUL_LAT-1:0], w_grant_any};
      r_tag_id[0] <= w_grant_idx;
      for (int s = 1; s <= MUL_LAT; s++) begin
        r_tag_id[s] <= r_tag_id[s-1];
      end
      // A retiring requester cannot be granted in the same cycle (it is
      // still outstanding), so set and clear never target the same bit.
      r_outstanding <= (r_outstanding & ~w_clr) | w_grant;
      r_rsp_valid   <= w_clr;
      if (w_retire) begin
        r_rsp_data <= mul_result;
      end
    end
  end

  assign req_ready = w_grant;
  assign mul_valid = r_mul_valid;
  assign mul_a     = r_mul_a;
  assign mul_b     = r_mul_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = |r_outstanding;

endmodule
`default_nettype wire

// File: tb/tb_fp16_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp16_mul_sched
// Purpose  : Directed self-checking bench for fp16_mul_sched (NREQ=4,
//            MUL_LAT=2). The multiplier is modelled as mul_a + mul_b delayed
//            by MUL_LAT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp16_mul_sched;
  localparam int NREQ    = 4;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_ready;
  logic        mul_valid;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] mul_result;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp16_mul_sched #(.NREQ(NREQ), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  // Multiplier model: sum of operands, MUL_LAT cycles later.
  logic [15:0] r_dly [0:MUL_LAT-1];
  always @(posedge clk) begin
    r_dly[0] <= mul_a + mul_b;
    for (int k = 1; k < MUL_LAT; k++) r_dly[k] <= r_dly[k-1];
  end
  assign mul_result = r_dly[MUL_LAT-1];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  // Leaves the bench one step after the edge of "cycle 0" with rst_n high.
  task automatic do_reset();
    rst_n = 1'b0; ena = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; req_valid = 4'hF; req_a = '1; req_b = '1;
    next_cycle();
    @(negedge clk);
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    total++; if (mul_valid !== 1'b0) begin bad++; $display("FAIL reset_mul_valid: got %b want 0", mul_valid); end
    total++; if (mul_a !== 16'h0 || mul_b !== 16'h0) begin bad++; $display("FAIL reset_mul_ops: got %h/%h want 0000/0000", mul_a, mul_b); end
    total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    total++; if (rsp_data !== 16'h0) begin bad++; $display("FAIL reset_rsp_data: got %h want 0000", rsp_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      req_valid = (c == 0) ? 4'b0100 : 4'b0000;
      if (c == 0) set_op(2, 16'h3C00, 16'h4000);
      @(negedge clk);
      total++; if (req_ready !== ((c == 0) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL single_ready c%0d: got %b", c, req_ready); end
      total++; if (mul_valid !== (c == 1)) begin bad++; $display("FAIL single_mul_valid c%0d: got %b want %b", c, mul_valid, c == 1); end
      if (c == 1) begin
        total++; if (mul_a !== 16'h3C00 || mul_b !== 16'h4000) begin bad++; $display("FAIL single_mul_ops: got %h/%h want 3c00/4000", mul_a, mul_b); end
      end
      total++; if (busy !== (c >= 1 && c <= 3)) begin bad++; $display("FAIL single_busy c%0d: got %b", c, busy); end
      total++; if (rsp_valid !== ((c == 4) ? 4'b0100 : 4'b0000)) begin bad++; $display("FAIL single_rsp_valid c%0d: got %b", c, rsp_valid); end
      if (c >= 4) begin
        total++; if (rsp_data !== 16'h7C00) begin bad++; $display("FAIL single_rsp_data c%0d: got %h want 7c00", c, rsp_data); end
      end
      next_cycle();
    end
  endtask

  task automatic test_contention();
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_op(i, 16'(i), 16'h0100);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      total++; if (req_ready !== (4'b0001 << (c % 4))) begin bad++; $display("FAIL cont_ready c%0d: got %b want %b", c, req_ready, 4'b0001 << (c % 4)); end
      if (c >= 1) begin
        total++; if (mul_valid !== 1'b1 || mul_a !== 16'((c - 1) % 4)) begin bad++; $display("FAIL cont_issue c%0d: got v=%b a=%h want v=1 a=%h", c, mul_valid, mul_a, (c - 1) % 4); end
      end
      if (c >= 4) begin
        total++; if (rsp_valid !== (4'b0001 << ((c - 4) % 4))) begin bad++; $display("FAIL cont_rsp_valid c%0d: got %b", c, rsp_valid); end
        total++; if (rsp_data !== 16'(16'h0100 + (c - 4) % 4)) begin bad++; $display("FAIL cont_rsp_data c%0d: got %h want %h", c, rsp_data, 16'h0100 + (c - 4) % 4); end
      end else begin
        total++; if (rsp_valid !== 4'b0000) begin bad++; $display("FAIL cont_rsp_idle c%0d: got %b want 0000", c, rsp_valid); end
      end
      next_cycle();
    end
    req_valid = '0;
  endtask

  task automatic test_outstanding();
    do_reset();
    req_valid = 4'b0010;
    set_op(1, 16'h0005, 16'h0007);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      total++; if (req_ready !== ((c % 4 == 0) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL outst_ready c%0d: got %b", c, req_ready); end
      total++; if (rsp_valid !== ((c == 4 || c == 8) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL outst_rsp c%0d: got %b", c, rsp_valid); end
      if (c == 4 || c == 8) begin
        total++; if (rsp_data !== 16'h000C) begin bad++; $display("FAIL outst_rsp_data c%0d: got %h want 000c", c, rsp_data); end
      end
      next_cycle();
    end
    req_valid = '0;
  endtask

  task automatic test_ena();
    // Part A: ena low blocks everything.
    do_reset();
    ena = 1'b0; req_valid = 4'hF;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL ena_ready c%0d: got %b want 0000", c, req_ready); end
      total++; if (mul_valid !== 1'b0) begin bad++; $display("FAIL ena_mul_valid c%0d: got %b want 0", c, mul_valid); end
      next_cycle();
    end
    // Part B: grants in cycles 0-1, ena low afterwards; in-flight ops drain.
    do_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 4; i++) set_op(i, 16'(16'h0010 * i), 16'h0001);
    for (int c = 0; c <= 6; c++) begin
      ena = (c <= 1 || c == 6);
      @(negedge clk);
      if (c <= 1) begin
        total++; if (req_ready !== (4'b0001 << c)) begin bad++; $display("FAIL enab_ready c%0d: got %b", c, req_ready); end
      end else if (c == 6) begin
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL enab_ptr_hold: got %b want 0100", req_ready); end
      end else begin
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL enab_blocked c%0d: got %b want 0000", c, req_ready); end
      end
      if (c == 4) begin
        total++; if (rsp_valid !== 4'b0001 || rsp_data !== 16'h0001) begin bad++; $display("FAIL enab_rsp0: got %b/%h want 0001/0001", rsp_valid, rsp_data); end
      end
      if (c == 5) begin
        total++; if (rsp_valid !== 4'b0010 || rsp_data !== 16'h0011) begin bad++; $display("FAIL enab_rsp1: got %b/%h want 0010/0011", rsp_valid, rsp_data); end
      end
      next_cycle();
    end
    req_valid = '0; ena = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      rst_n = (c != 2);
      req_valid = (c == 0) ? 4'b0001 : (c == 3) ? 4'b0010 : 4'b0000;
      if (c == 0) set_op(0, 16'h0001, 16'h0002);
      if (c == 3) set_op(1, 16'h0003, 16'h0004);
      @(negedge clk);
      if (c == 3) begin
        total++; if (busy !== 1'b0 || rsp_data !== 16'h0000) begin bad++; $display("FAIL rmid_cleared: got busy=%b data=%h want 0/0000", busy, rsp_data); end
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rmid_regrant: got %b want 0010", req_ready); end
      end
      total++; if (rsp_valid !== ((c == 7) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL rmid_rsp c%0d: got %b", c, rsp_valid); end
      if (c == 7) begin
        total++; if (rsp_data !== 16'h0007) begin bad++; $display("FAIL rmid_rsp_data: got %h want 0007", rsp_data); end
      end
      next_cycle();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_operand_change();
    do_reset();
    set_op(0, 16'h00AA, 16'h0000);
    set_op(3, 16'h1111, 16'h0001);
    for (int c = 0; c <= 5; c++) begin
      req_valid = (c == 0) ? 4'b1001 : (c == 1) ? 4'b1000 : 4'b0000;
      if (c == 1) set_op(3, 16'h2222, 16'h0001);
      @(negedge clk);
      if (c == 0) begin
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL opchg_first: got %b want 0001", req_ready); end
      end
      if (c == 1) begin
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL opchg_second: got %b want 1000", req_ready); end
      end
      if (c == 2) begin
        total++; if (mul_valid !== 1'b1 || mul_a !== 16'h2222 || mul_b !== 16'h0001) begin bad++; $display("FAIL opchg_issue: got %b %h/%h want 1 2222/0001", mul_valid, mul_a, mul_b); end
      end
      if (c == 4) begin
        total++; if (rsp_valid !== 4'b0001 || rsp_data !== 16'h00AA) begin bad++; $display("FAIL opchg_rsp0: got %b/%h want 0001/00aa", rsp_valid, rsp_data); end
      end
      if (c == 5) begin
        total++; if (rsp_valid !== 4'b1000 || rsp_data !== 16'h2223) begin bad++; $display("FAIL opchg_rsp3: got %b/%h want 1000/2223", rsp_valid, rsp_data); end
      end
      next_cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    test_reset();
    test_single();
    test_contention();
    test_outstanding();
    test_ena();
    test_reset_mid();
    test_operand_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
